// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, decoded-instruction record, issue payload
// record and the instruction decoder shared by the issue stage.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Decoded instruction: which sources are read, where the result goes
    typedef struct packed {
        logic              use_a;
        logic              use_b;
        logic [RIDX_W-1:0] src_a;
        logic [RIDX_W-1:0] src_b;
        logic [RIDX_W-1:0] dest;
        logic              wen;
        logic              illegal;
    } dec_t;

    // Payload handed to the ALU
    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [XLEN-1:0]   reg_a;
        logic [XLEN-1:0]   reg_b;
        logic [RIDX_W-1:0] dest;
        logic              wen;
        logic              illegal;
    } issue_pkt_t;

    // Classify an instruction; unsupported encodings read nothing and write nothing
    function automatic dec_t decode(
        input logic [5:0]        op,
        input logic [5:0]        fn,
        input logic [RIDX_W-1:0] rs,
        input logic [RIDX_W-1:0] rt,
        input logic [RIDX_W-1:0] rd
    );
        dec_t d;
        d       = '0;
        d.src_a = rs;
        d.src_b = rt;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        d.use_a = 1'b1;
                        d.use_b = 1'b1;
                        d.dest  = rd;
                        d.wen   = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_SLTIU, OP_LW: begin
                d.use_a = 1'b1;
                d.dest  = rt;
                d.wen   = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                d.use_a = 1'b1;
                d.use_b = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        // r0 is hardwired, never a real write target
        if (d.dest == '0) begin
            d.wen = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: fetch offer, ALU issue handshake and ALU writeback bundle.
//   master: environment side (fetch + ALU); drives in_*, out_ready, wb_*
//   slave : issue unit; drives in_ready and out_* payload
interface alu_issue_if;
    import mips_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_regA;
    logic [XLEN-1:0]   out_regB;
    logic [RIDX_W-1:0] out_dest;
    logic              out_wen;
    logic              out_illegal;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_dest;
    logic [XLEN-1:0]   wb_data;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_dest, wb_data,
        input  in_ready, out_valid, out_instr, out_regA, out_regB,
               out_dest, out_wen, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_dest, wb_data,
        output in_ready, out_valid, out_instr, out_regA, out_regB,
               out_dest, out_wen, out_illegal
    );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: NREG x 32 register file, two combinational read ports, one
// synchronous write port. Entry 0 always reads zero and is never written.
//   clk, rst_n        : clock, synchronous active-low reset (clears all entries)
//   addr_a/data_a_c   : read port A
//   addr_b/data_b_c   : read port B
//   wr_en/addr/data   : write port
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] addr_a,
    output logic [XLEN-1:0]   data_a_c,
    input  logic [RIDX_W-1:0] addr_b,
    output logic [XLEN-1:0]   data_b_c,
    input  logic              wr_en,
    input  logic [RIDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] mem [NREG];

    // Storage update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports
    assign data_a_c = (addr_a == '0) ? '0 : mem[addr_a];
    assign data_b_c = (addr_b == '0) ? '0 : mem[addr_b];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue stage. Decodes the offered instruction, reads
// operands (with same-cycle writeback bypass), stalls on pending sources and
// hands a registered payload to the ALU one cycle after acceptance.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_issue_if.slave (fetch offer, ALU issue, ALU writeback)
module alu_issue
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_next;
    dec_t            dec;
    issue_pkt_t      pkt_q, pkt_d;
    logic [XLEN-1:0] rf_a, rf_b, opnd_a, opnd_b;
    logic [NREG-1:0] pending, pend_set, pend_clr;
    logic            wb_hit_a, wb_hit_b;
    logic            hazard, in_ready_c, accept;

    assign dec = decode(bus.in_instr[31:26], bus.in_instr[5:0],
                        bus.in_instr[25:21], bus.in_instr[20:16],
                        bus.in_instr[15:11]);

    mips_regfile #(.NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_a   (dec.src_a),
        .data_a_c (rf_a),
        .addr_b   (dec.src_b),
        .data_b_c (rf_b),
        .wr_en    (bus.wb_valid),
        .wr_addr  (bus.wb_dest),
        .wr_data  (bus.wb_data)
    );

    // Same-cycle writeback bypass; r0 never forwards
    assign wb_hit_a = bus.wb_valid && (bus.wb_dest == dec.src_a) && (dec.src_a != '0);
    assign wb_hit_b = bus.wb_valid && (bus.wb_dest == dec.src_b) && (dec.src_b != '0);
    assign opnd_a   = wb_hit_a ? bus.wb_data : rf_a;
    assign opnd_b   = wb_hit_b ? bus.wb_data : rf_b;

    // A pending source only stalls if its result is not arriving right now
    assign hazard = (dec.use_a && pending[dec.src_a] &&
                     !(bus.wb_valid && (bus.wb_dest == dec.src_a))) ||
                    (dec.use_b && pending[dec.src_b] &&
                     !(bus.wb_valid && (bus.wb_dest == dec.src_b)));

    assign in_ready_c   = rst_n && ((state == EMPTY) || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && in_ready_c;
    assign bus.in_ready = in_ready_c;

    // Scoreboard: set wins over a same-cycle clear
    assign pend_set = (accept && dec.wen) ? (NREG'(1) << dec.dest) : '0;
    assign pend_clr = bus.wb_valid ? (NREG'(1) << bus.wb_dest) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    // Output slot state register and payload register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            pkt_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pkt_q <= pkt_d;
            end
        end
    end

    // Next state and next payload
    always_comb begin
        state_next    = state;
        pkt_d         = '0;
        pkt_d.instr   = bus.in_instr;
        pkt_d.reg_a   = dec.use_a ? opnd_a : '0;
        pkt_d.reg_b   = dec.use_b ? opnd_b : '0;
        pkt_d.dest    = dec.dest;
        pkt_d.wen     = dec.wen;
        pkt_d.illegal = dec.illegal;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (bus.out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign bus.out_valid   = (state == FULL);
    assign bus.out_instr   = pkt_q.instr;
    assign bus.out_regA    = pkt_q.reg_a;
    assign bus.out_regB    = pkt_q.reg_b;
    assign bus.out_dest    = pkt_q.dest;
    assign bus.out_wen     = pkt_q.wen;
    assign bus.out_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scenarios followed by random traffic. A reference
// model updated per cycle predicts in_ready and the payload of every accepted
// instruction; a monitor compares them against what the issue stage presents.
module tb_alu_issue;

    typedef struct {
        int          from;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wen;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_issue_if bus();

    alu_issue #(.NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    exp_t        q[$];
    bit          exp_ready = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          last_rst = 1'b0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_full = 1'b0;

    logic [5:0]  rfn [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0]  iop [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23};
    logic [5:0]  sop [3]  = '{6'h2B, 6'h04, 6'h05};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // 0: register ALU op, 1: immediate/load, 2: store/branch, 3: unsupported
    function automatic int kind_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00)
            return (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                               [6'h20:6'h27], 6'h2A, 6'h2B}) ? 0 : 3;
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23}) return 1;
        if (op inside {6'h2B, 6'h04, 6'h05}) return 2;
        return 3;
    endfunction

    // One clock: drive inputs, predict this edge's outcome, advance the model
    task automatic step(input bit iv, input logic [31:0] ins, input bit ordy,
                        input bit wbv, input logic [4:0] wbd, input logic [31:0] wbdat);
        int          k;
        logic [4:0]  a, b, d;
        bit          ua, ub, haz, acc, wen, busy_a, busy_b;
        logic [31:0] va, vb;
        exp_t        e;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_valid  = wbv;
        bus.wb_dest   = wbd;
        bus.wb_data   = wbdat;

        k  = kind_of(ins);
        a  = ins[25:21];
        b  = ins[20:16];
        ua = (k != 3);
        ub = (k == 0) || (k == 2);
        busy_a = m_pend[a] && !(wbv && wbd == a);
        busy_b = m_pend[b] && !(wbv && wbd == b);
        haz = (ua && busy_a) || (ub && busy_b);
        exp_ready = rst_n && (!m_full || ordy) && !haz;
        acc = iv && exp_ready;

        d   = (k == 0) ? ins[15:11] : (k == 1) ? ins[20:16] : 5'd0;
        wen = (k <= 1) && (d != 5'd0);
        if (acc) begin
            va = (a == 5'd0) ? 32'd0 : (wbv && wbd == a) ? wbdat : m_regs[a];
            vb = (b == 5'd0) ? 32'd0 : (wbv && wbd == b) ? wbdat : m_regs[b];
            e.from  = cycle + 1;
            e.instr = ins;
            e.a     = ua ? va : 32'd0;
            e.b     = ub ? vb : 32'd0;
            e.dest  = d;
            e.wen   = wen;
            e.ill   = (k == 3);
            q.push_back(e);
        end

        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_full = 1'b0;
        end else begin
            if (wbv) begin
                if (wbd != 5'd0) m_regs[wbd] = wbdat;
                m_pend[wbd] = 1'b0;
            end
            if (acc && wen) m_pend[d] = 1'b1;
            m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        step(1'b0, 32'd0, 1'b1, 1'b1, r, v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cycle);
        end
    endtask

    // Monitor: compares presented outputs with the oldest predicted entry
    always @(negedge clk) begin
        if (last_rst) begin
            chk("rst_out_instr",   bus.out_instr, 32'd0);
            chk("rst_out_regA",    bus.out_regA, 32'd0);
            chk("rst_out_regB",    bus.out_regB, 32'd0);
            chk("rst_out_dest",    32'(bus.out_dest), 32'd0);
            chk("rst_out_wen",     32'(bus.out_wen), 32'd0);
            chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        end
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (q.size() > 0 && q[0].from <= cycle) begin
            chk("out_valid",   32'(bus.out_valid), 32'd1);
            chk("out_instr",   bus.out_instr, q[0].instr);
            chk("out_regA",    bus.out_regA, q[0].a);
            chk("out_regB",    bus.out_regB, q[0].b);
            chk("out_dest",    32'(bus.out_dest), 32'(q[0].dest));
            chk("out_wen",     32'(bus.out_wen), 32'(q[0].wen));
            chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
            if (bus.out_ready) void'(q.pop_front());
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'd0);
        end
        if (!rst_n) q.delete();
        last_rst = !rst_n;
    end

    initial begin
        logic [31:0] ins;
        logic [4:0]  rs, rt, rd;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_dest   = 5'd0;
        bus.wb_data   = 32'd0;
        @(posedge clk);
        #1;
        idle();
        idle();
        rst_n = 1'b1;
        idle();

        // add r3,r1,r2 with r1=5, r2=7
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        step(1'b1, 32'h0022_1820, 1'b1, 1'b0, 5'd0, 32'd0);
        idle();

        // addi r4,r3,1 then addu r5,r4,r4 stalls until r4 writes back
        wb(5'd3, 32'd12);
        step(1'b1, itype(6'h08, 5'd3, 5'd4, 16'd1), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h21), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h21), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h21), 1'b1, 1'b1, 5'd4, 32'd9);
        idle();
        wb(5'd5, 32'd18);

        // ALU stall for 3 cycles, then back-to-back issue
        step(1'b1, itype(6'h0D, 5'd0, 5'd7, 16'h1234), 1'b1, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, itype(6'h0C, 5'd0, 5'd1, 16'h00FF), 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, itype(6'h0C, 5'd0, 5'd1, 16'h00FF), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, itype(6'h0E, 5'd0, 5'd2, 16'd7), 1'b1, 1'b0, 5'd0, 32'd0);
        idle();
        wb(5'd7, 32'h1234);
        wb(5'd1, 32'hFF);
        wb(5'd2, 32'd7);

        // Unsupported opcode, write to r0, writeback to r0
        step(1'b1, itype(6'h3F, 5'd1, 5'd2, 16'd0), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h01), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, itype(6'h08, 5'd0, 5'd0, 16'd5), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd0, 5'd0, 5'd8, 6'h21), 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step(1'b1, rtype(5'd0, 5'd0, 5'd9, 6'h21), 1'b1, 1'b0, 5'd0, 32'd0);
        idle();
        wb(5'd8, 32'd0);
        wb(5'd9, 32'd0);

        // Reset while an instruction is stalled and r6 is pending
        wb(5'd6, 32'h55);
        step(1'b1, itype(6'h0D, 5'd0, 5'd6, 16'd1), 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        step(1'b1, itype(6'h2B, 5'd6, 5'd6, 16'd0), 1'b1, 1'b0, 5'd0, 32'd0);
        idle();

        // Random traffic on r0..r7 to stress hazards and bypass
        for (int n = 0; n < 600; n++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0, 1:    ins = rtype(rs, rt, rd, rfn[$urandom_range(0, 15)]);
                2, 3:    ins = itype(iop[$urandom_range(0, 7)], rs, rt, 16'($urandom));
                4:       ins = itype(sop[$urandom_range(0, 2)], rs, rt, 16'($urandom));
                5:       ins = itype(6'h3F, rs, rt, 16'($urandom));
                default: ins = rtype(rs, rt, rd, 6'h01);
            endcase
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers; register 0 reads as zero.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32: instruction offer from fetch.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1: issue handshake toward the ALU.
REQ-006 SHALL have ports out_instr output 32, out_regA output 32, out_regB output 32: ALU instruction and operand values.
REQ-007 SHALL have ports out_dest output 5, out_wen output 1, out_illegal output 1: writeback target, write enable, unsupported-opcode marker.
REQ-008 SHALL have ports wb_valid input 1, wb_dest input 5, wb_data input 32: result writeback from the ALU side.

Function
REQ-009 SHALL accept an instruction when in_valid and in_ready are both high at a rising edge.
REQ-010 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinationally.
REQ-011 SHALL decode opcode 0 (R-type): sources rs[25:21], rt[20:16]; dest rd[15:11]; wen=1 for add,addu,sub,subu,and,or,xor,nor,slt,sltu,sll,sllv,srl,srlv,sra,srav.
REQ-012 SHALL decode addi,addiu,andi,ori,xori,slti,sltiu,lw: source rs only; dest rt; wen=1.
REQ-013 SHALL decode sw,beq,bne: sources rs and rt; wen=0.
REQ-014 SHALL mark any other opcode/funct illegal: issue with wen=0, out_illegal=1, no hazard check.
REQ-015 SHALL force wen=0 whenever the decoded dest is register 0.
REQ-016 SHALL keep a per-register pending bit: set at issue acceptance when wen=1, cleared when wb_valid targets that register.
REQ-017 SHALL assert hazard when any used source register is pending and not being written back in the same cycle.
REQ-018 SHALL bypass: a source matching wb_dest with wb_valid=1 takes wb_data, not the register file value.
REQ-019 SHALL, on simultaneous set and clear of the same pending bit, leave it set.
REQ-020 SHALL write wb_data into the register file on wb_valid unless wb_dest is 0.
REQ-021 SHALL present out_* exactly one cycle after acceptance (latency 1).
REQ-022 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL implement output FSM EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept (back-to-back, full throughput).
REQ-024 SHALL drive unused operand (regB for I-type) as zero.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, clear out_valid, out_wen, out_illegal, out_dest, out_instr, out_regA, out_regB to 0 and all pending bits to 0.
REQ-026 SHALL clear all register file entries to 0 on reset.
REQ-027 SHALL discard an instruction held in FULL state when reset asserts mid-stall; no writeback is issued for it.
REQ-028 SHALL hold in_ready low during reset.

Structure
REQ-029 SHALL take opcode and funct constants and the decoded-instruction record type from shared package mips_pkg.
REQ-030 SHALL instantiate one sub-module mips_regfile (two read ports, one write port, write-before-read bypass internal to alu_issue).

Verification
REQ-031 SHALL cover: write r1=5, r2=7 via wb; issue add r3,r1,r2 (0x00221820) -> next cycle out_regA=5, out_regB=7, out_dest=3, out_wen=1.
REQ-032 SHALL cover: issue addi r4,r3,1 then addu r5,r4,r4 with no wb -> in_ready=0 for second; wb r4=9 -> same cycle in_ready=1, out_regA=out_regB=9.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 with in_valid=1 -> new instruction issued next cycle, no bubble.
REQ-034 SHALL cover: opcode 0x3F -> out_illegal=1, out_wen=0; addi r0,r0,5 -> out_wen=0; wb to r0 of 0xFFFFFFFF -> r0 still reads 0.
REQ-035 SHALL cover: rst_n=0 while FULL and r6 pending -> next cycle out_valid=0, pending clear, sw r6,r6 issues immediately with regA=regB=0.
